// File: rtl/req_encoder16x4_pkg.sv
// Shared constants, types and helpers for the 16-to-4 request encoder.
package req_encoder16x4_pkg;

  localparam int N_LINES = 16;
  localparam int CODE_W  = 4;

  // Values for the ROUND_ROBIN parameter of the top level.
  localparam bit MODE_FIXED = 1'b0;
  localparam bit MODE_RR    = 1'b1;

  typedef logic [N_LINES-1:0] line_vec_t;
  typedef logic [CODE_W-1:0]  code_t;

  // Direction in which the priority picker walks away from its start index.
  typedef enum logic {
    SCAN_DOWN = 1'b0,
    SCAN_UP   = 1'b1
  } scan_dir_t;

  // Fixed priority starts at the top line and walks downward.
  localparam code_t FIXED_START = code_t'(N_LINES - 1);

  // Expand a line index into its one-hot line vector.
  function automatic line_vec_t onehot(input code_t idx);
    line_vec_t vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/req_encoder16x4_prio_pick16.sv
// Combinational circular priority picker over 16 candidate lines.
// Returns the first set line met when walking from start in direction dir,
// wrapping modulo 16; the start line itself has the highest priority.
module prio_pick16
  import req_encoder16x4_pkg::*;
(
  input  logic [N_LINES-1:0] cand,
  input  logic [CODE_W-1:0]  start,
  input  scan_dir_t          dir,
  output logic [CODE_W-1:0]  idx,
  output logic               any
);

  code_t pos;

  // Walk from the farthest line back to the start so the nearest hit is the last write.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned and no latch is inferred.
    idx = '0;
    pos = '0;
    any = |cand;
    for (int k = N_LINES - 1; k >= 0; k--) begin
      pos = (dir == SCAN_UP) ? start + code_t'(k) : start - code_t'(k);
      if (cand[pos]) begin
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/req_encoder16x4.sv
// Sequential 16-to-4 request encoder. Request lines are folded into sticky
// pending bits and served one at a time as a 4-bit code over valid/ready.
// Selection is fixed (highest index wins) or rotating, chosen by ROUND_ROBIN.
module req_encoder16x4
  import req_encoder16x4_pkg::*;
#(
  parameter bit ROUND_ROBIN = MODE_FIXED
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_LINES-1:0] req,
  input  logic [N_LINES-1:0] mask,
  output logic [CODE_W-1:0]  code,
  output logic               valid,
  input  logic               ready,
  output logic [N_LINES-1:0] pending,
  output logic               overrun
);

  logic      handshake;
  line_vec_t clr;
  line_vec_t req_in;
  line_vec_t pending_next;
  logic      overrun_next;
  line_vec_t cand;
  logic      load;
  code_t     ptr;
  code_t     ptr_eff;
  code_t     pick_start;
  scan_dir_t pick_dir;
  code_t     pick_idx;
  logic      pick_any;

  // The line being granted this cycle is cleared, but a new request on the
  // same line wins and keeps it pending.
  assign handshake    = valid && ready;
  assign clr          = handshake ? onehot(code) : '0;
  assign req_in       = en ? req : '0;
  assign pending_next = (pending & ~clr) | req_in;
  assign overrun_next = |(req_in & pending & ~clr);

  // Candidates exclude the line leaving this cycle, so back-to-back grants
  // never repeat a code that was just accepted.
  assign cand = pending & ~mask & ~clr;
  assign load = !valid || ready;

  // Rotating priority looks past the code being accepted right now, so the
  // pointer advance takes effect on the very next pick.
  assign ptr_eff    = handshake ? code + 4'd1 : ptr;
  assign pick_start = (ROUND_ROBIN == MODE_RR) ? ptr_eff : FIXED_START;
  assign pick_dir   = (ROUND_ROBIN == MODE_RR) ? SCAN_UP : SCAN_DOWN;

  prio_pick16 u_pick (
    .cand  (cand),
    .start (pick_start),
    .dir   (pick_dir),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Pending, overrun, rotation pointer and output registers; reset overrides any held handshake.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked block and not in the sensitivity list.
    if (!rst_n) begin
      pending <= '0;
      overrun <= 1'b0;
      ptr     <= '0;
      valid   <= 1'b0;
      code    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
      pending <= pending_next;
      overrun <= overrun_next;
      if (handshake) begin
        ptr <= code + 4'd1;
      end
      if (load) begin
        valid <= pick_any;
        if (pick_any) begin
          code <= pick_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_req_encoder16x4.sv
// Self-checking bench for req_encoder16x4. A fixed-priority and a rotating
// instance share all inputs; sel_rr chooses which one the checks observe.
// Expected codes are queued when requests are driven and popped on each
// handshake seen at the falling edge.
module tb_req_encoder16x4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] req   = '0;
  logic [15:0] mask  = '0;

  logic [3:0]  code_fix, code_rr;
  logic        valid_fix, valid_rr;
  logic        overrun_fix, overrun_rr;
  logic [15:0] pending_fix, pending_rr;

  bit          sel_rr = 1'b0;
  logic [3:0]  code;
  logic        valid;
  logic        overrun;
  logic [15:0] pending;

  int          checks   = 0;
  int          failures = 0;
  logic [3:0]  exp_q[$];

  assign code    = sel_rr ? code_rr    : code_fix;
  assign valid   = sel_rr ? valid_rr   : valid_fix;
  assign overrun = sel_rr ? overrun_rr : overrun_fix;
  assign pending = sel_rr ? pending_rr : pending_fix;

  always #5 clk = ~clk;

  req_encoder16x4 #(.ROUND_ROBIN(1'b0)) dut_fix (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .mask    (mask),
    .code    (code_fix),
    .valid   (valid_fix),
    .ready   (ready),
    .pending (pending_fix),
    .overrun (overrun_fix)
  );

  req_encoder16x4 #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .mask    (mask),
    .code    (code_rr),
    .valid   (valid_rr),
    .ready   (ready),
    .pending (pending_rr),
    .overrun (overrun_rr)
  );

  task automatic drive(input logic [15:0] r, input logic e, input logic [15:0] m, input logic rdy);
    req   = r;
    en    = e;
    mask  = m;
    ready = rdy;
  endtask

  task automatic apply_reset();
    drive(16'h0000, 1'b0, 16'h0000, 1'b0);
    exp_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pop and compare one expected code if a handshake happens at the coming edge.
  task automatic sb_tick();
    logic [3:0] e;
    if (valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got code %0d, required no handshake", code);
      end else begin
        e = exp_q.pop_front();
        if (code !== e) begin
          failures++;
          $display("FAIL sb_code: got %0d, required %0d", code, e);
        end
      end
    end
  endtask

  // Serve queued codes within a cycle budget, then step one more edge.
  task automatic drain(input int budget);
    int n;
    n = 0;
    sb_tick();
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
      sb_tick();
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_timeout: %0d codes still expected after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    sel_rr = 1'b0;
    rst_n  = 1'b0;
    drive(16'hFFFF, 1'b1, 16'h0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++; if (pending !== 16'h0000) begin failures++; $display("FAIL reset_pending: got %h, required 0000", pending); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b, required 0", valid); end
    checks++; if (code !== 4'd0) begin failures++; $display("FAIL reset_code: got %0d, required 0", code); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    rst_n = 1'b1;
    drive(16'h0000, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_fixed_basic();
    sel_rr = 1'b0;
    apply_reset();
    drive(16'h0081, 1'b1, 16'h0000, 1'b1);
    exp_q.push_back(4'd7);
    exp_q.push_back(4'd0);
    @(negedge clk);
    req = 16'h0000;
    checks++; if (pending !== 16'h0081) begin failures++; $display("FAIL basic_pending: got %h, required 0081", pending); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL basic_latency: valid got %b, required 0", valid); end
    drain(6);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL basic_idle: valid got %b, required 0", valid); end
    checks++; if (pending !== 16'h0000) begin failures++; $display("FAIL basic_empty: pending got %h, required 0000", pending); end
  endtask

  task automatic test_hold();
    sel_rr = 1'b0;
    apply_reset();
    drive(16'h0004, 1'b1, 16'h0000, 1'b0);
    @(negedge clk);
    req = 16'h8000;
    @(negedge clk);
    req = 16'h0000;
    checks++; if (valid !== 1'b1 || code !== 4'd2) begin failures++; $display("FAIL hold_offer: got valid=%b code=%0d, required valid=1 code=2", valid, code); end
    @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 4'd2) begin failures++; $display("FAIL hold_stable: got valid=%b code=%0d, required valid=1 code=2", valid, code); end
    checks++; if (pending !== 16'h8004) begin failures++; $display("FAIL hold_pending: got %h, required 8004", pending); end
    ready = 1'b1;
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd15);
    sb_tick();
    @(negedge clk);
    checks++; if (pending !== 16'h8000) begin failures++; $display("FAIL hold_after_grant: pending got %h, required 8000", pending); end
    drain(4);
    checks++; if (pending !== 16'h0000 || valid !== 1'b0) begin failures++; $display("FAIL hold_done: got pending=%h valid=%b, required 0000/0", pending, valid); end
  endtask

  task automatic test_rr_sweep();
    sel_rr = 1'b1;
    apply_reset();
    drive(16'hFFFF, 1'b1, 16'h0000, 1'b1);
    for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
    @(negedge clk);
    req = 16'h0000;
    drain(24);
    checks++; if (valid !== 1'b0 || pending !== 16'h0000) begin failures++; $display("FAIL rr_sweep_done: got valid=%b pending=%h, required 0/0000", valid, pending); end
    // Pointer back at 0: line 0 must beat line 15.
    drive(16'h8001, 1'b1, 16'h0000, 1'b1);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd15);
    @(negedge clk);
    req = 16'h0000;
    drain(6);
    // Pointer now 0 again after serving 15: line 2 comes before line 9.
    drive(16'h0204, 1'b1, 16'h0000, 1'b1);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd9);
    @(negedge clk);
    req = 16'h0000;
    drain(6);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rr_idle: valid got %b, required 0", valid); end
    sel_rr = 1'b0;
  endtask

  task automatic test_regrant();
    sel_rr = 1'b0;
    apply_reset();
    drive(16'h0008, 1'b1, 16'h0000, 1'b1);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd3);
    @(negedge clk);
    req = 16'h0000;
    @(negedge clk);
    req = 16'h0008;
    sb_tick();
    @(negedge clk);
    req = 16'h0000;
    checks++; if (pending !== 16'h0008) begin failures++; $display("FAIL regrant_pending: got %h, required 0008", pending); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL regrant_overrun: got %b, required 0", overrun); end
    drain(4);
    checks++; if (pending !== 16'h0000 || valid !== 1'b0) begin failures++; $display("FAIL regrant_done: got pending=%h valid=%b, required 0000/0", pending, valid); end
  endtask

  task automatic test_overrun();
    sel_rr = 1'b0;
    apply_reset();
    drive(16'h0010, 1'b1, 16'h0000, 1'b0);
    @(negedge clk);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_first: got %b, required 0", overrun); end
    @(negedge clk);
    req = 16'h0000;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_pulse: got %b, required 1", overrun); end
    @(negedge clk);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_single: got %b, required 0", overrun); end
    checks++; if (valid !== 1'b1 || code !== 4'd4) begin failures++; $display("FAIL overrun_offer: got valid=%b code=%0d, required 1/4", valid, code); end
    ready = 1'b1;
    exp_q.push_back(4'd4);
    drain(4);
    // Capture disabled: requests are ignored entirely.
    drive(16'hFFFF, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++; if (pending !== 16'h0000 || valid !== 1'b0) begin failures++; $display("FAIL en_low: got pending=%h valid=%b, required 0000/0", pending, valid); end
  endtask

  task automatic test_mask_and_reset();
    sel_rr = 1'b0;
    apply_reset();
    drive(16'h0101, 1'b1, 16'h00FF, 1'b1);
    exp_q.push_back(4'd8);
    @(negedge clk);
    req = 16'h0000;
    drain(6);
    checks++; if (pending !== 16'h0001 || valid !== 1'b0) begin failures++; $display("FAIL mask_kept: got pending=%h valid=%b, required 0001/0", pending, valid); end
    @(negedge clk);
    checks++; if (pending !== 16'h0001 || valid !== 1'b0) begin failures++; $display("FAIL mask_blocked: got pending=%h valid=%b, required 0001/0", pending, valid); end
    mask = 16'h0000;
    exp_q.push_back(4'd0);
    drain(4);
    checks++; if (pending !== 16'h0000 || valid !== 1'b0) begin failures++; $display("FAIL unmask_done: got pending=%h valid=%b, required 0000/0", pending, valid); end
    // Hold an offer, mask it (no retraction), then reset over the held handshake.
    drive(16'h0002, 1'b1, 16'h0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 4'd1 || overrun !== 1'b1) begin failures++; $display("FAIL held_offer: got valid=%b code=%0d overrun=%b, required 1/1/1", valid, code, overrun); end
    mask = 16'h0002;
    @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 4'd1) begin failures++; $display("FAIL mask_no_retract: got valid=%b code=%0d, required 1/1", valid, code); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (pending !== 16'h0000 || valid !== 1'b0 || code !== 4'd0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_hold: got pending=%h valid=%b code=%0d overrun=%b, required 0000/0/0/0", pending, valid, code, overrun);
    end
    rst_n = 1'b1;
    drive(16'h0000, 1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fixed_basic();
    test_hold();
    test_rr_sweep();
    test_regrant();
    test_overrun();
    test_mask_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 100000");
    $fatal(1, "time limit reached");
  end

endmodule
